// File: rtl/decoder_stage_controller_pkg.sv
// Shared decoder parameters: stage codes broadcast to the processing units
// and the controller's state type, which reuses those codes directly.
package decoder_stage_controller_pkg;

  localparam int STAGE_WIDTH = 3;

  localparam logic [STAGE_WIDTH-1:0] STAGE_IDLE                = 3'd0;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1;
  localparam logic [STAGE_WIDTH-1:0] STAGE_ERASURE_LOADING     = 3'd2;
  localparam logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd3;
  localparam logic [STAGE_WIDTH-1:0] STAGE_MERGE               = 3'd4;
  localparam logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd5;
  localparam logic [STAGE_WIDTH-1:0] STAGE_RESULT_VALID        = 3'd6;

  // Wide enough for the largest legal MERGE/PEELING minimum dwell (15).
  localparam int DELAY_WIDTH = 4;

  // Controller states are encoded as the stage they broadcast, so the
  // registered state can drive global_stage with no decode.
  typedef enum logic [STAGE_WIDTH-1:0] {
    ST_IDLE                = STAGE_IDLE,
    ST_MEASUREMENT_LOADING = STAGE_MEASUREMENT_LOADING,
    ST_GROW                = STAGE_GROW,
    ST_MERGE               = STAGE_MERGE,
    ST_PEELING             = STAGE_PEELING,
    ST_RESULT_VALID        = STAGE_RESULT_VALID
  } state_e;

endpackage

// File: rtl/decoder_stage_controller.sv
// Round sequencer for the decoder array: walks LOADING -> (MERGE/GROW)* ->
// PEELING -> RESULT_VALID, broadcasting the current stage to all PUs and
// tracking growth iterations, decode latency and iteration timeout.
module decoder_stage_controller
  import decoder_stage_controller_pkg::*;
#(
  parameter int PU_COUNT                = 16,
  parameter int ITERATION_COUNTER_WIDTH = 8,
  parameter int MAXIMUM_DELAY           = 3,   // legal 2..15
  parameter int MAX_ITERATIONS          = 255
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               new_round_start,
  input  logic [PU_COUNT-1:0]                is_odd_cluster,
  input  logic [PU_COUNT-1:0]                is_busy,
  output logic [STAGE_WIDTH-1:0]             global_stage,
  output logic [ITERATION_COUNTER_WIDTH-1:0] iteration_counter,
  output logic [31:0]                        cycle_counter,
  output logic                               result_valid,
  output logic                               timeout
);

  localparam int ITW = ITERATION_COUNTER_WIDTH;
  localparam logic [DELAY_WIDTH-1:0] DELAY_MAX  = DELAY_WIDTH'(MAXIMUM_DELAY);
  localparam logic [ITW-1:0]         ITER_LIMIT = ITW'(MAX_ITERATIONS);

  state_e                 state_q, state_d;
  logic [DELAY_WIDTH-1:0] delay_q, delay_d, delay_inc;
  logic [ITW-1:0]         iter_q, iter_d;
  logic [31:0]            cyc_q, cyc_d;
  logic                   rv_q, rv_d;
  logic                   to_q, to_d;

  logic any_odd, any_busy, at_limit, accept, stage_done, active;

  // Shared decode terms: array-wide OR-reductions and dwell/exit condition.
  // delay_inc is the number of cycles spent in MERGE/PEELING including the
  // current one (saturating), so a stage lasts exactly MAXIMUM_DELAY cycles
  // when the array is idle.
  always_comb begin
    any_odd    = |is_odd_cluster;
    any_busy   = |is_busy;
    at_limit   = (iter_q >= ITER_LIMIT);
    accept     = (state_q == ST_IDLE) && new_round_start;
    delay_inc  = (delay_q >= DELAY_MAX) ? DELAY_MAX : delay_q + DELAY_WIDTH'(1);
    stage_done = (delay_inc >= DELAY_MAX) && !any_busy;
    active     = (state_q == ST_MEASUREMENT_LOADING) || (state_q == ST_GROW) ||
                 (state_q == ST_MERGE) || (state_q == ST_PEELING);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:                if (new_round_start) state_d = ST_MEASUREMENT_LOADING;
      ST_MEASUREMENT_LOADING: state_d = ST_MERGE;
      ST_GROW:                state_d = ST_MERGE;
      ST_MERGE:
        if (stage_done) state_d = (any_odd && !at_limit) ? ST_GROW : ST_PEELING;
      ST_PEELING:             if (stage_done) state_d = ST_RESULT_VALID;
      ST_RESULT_VALID:        state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the dwell counter.
  always_comb begin
    iter_d  = iter_q;
    cyc_d   = cyc_q;
    to_d    = to_q;
    rv_d    = (state_d == ST_RESULT_VALID);
    // Dwell counter restarts whenever MERGE/PEELING is (re)entered.
    delay_d = '0;
    if ((state_q == ST_MERGE || state_q == ST_PEELING) && state_d == state_q)
      delay_d = delay_inc;

    if (accept) begin
      iter_d = '0;
      cyc_d  = '0;
      to_d   = 1'b0;
    end else begin
      if (active && cyc_q != 32'hFFFF_FFFF) cyc_d = cyc_q + 32'd1;
      if (state_q == ST_MERGE && state_d == ST_GROW) iter_d = iter_q + ITW'(1);
      if (state_q == ST_MERGE && stage_done && any_odd && at_limit) to_d = 1'b1;
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      delay_q <= '0;
      iter_q  <= '0;
      cyc_q   <= '0;
      rv_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      delay_q <= delay_d;
      iter_q  <= iter_d;
      cyc_q   <= cyc_d;
      rv_q    <= rv_d;
      to_q    <= to_d;
    end
  end

  assign global_stage      = state_q;
  assign iteration_counter = iter_q;
  assign cycle_counter     = cyc_q;
  assign result_valid      = rv_q;
  assign timeout           = to_q;

endmodule

// File: tb/tb_decoder_stage_controller.sv
// Bench for decoder_stage_controller (PU_COUNT=4, MAXIMUM_DELAY=3,
// MAX_ITERATIONS=5). A round-level model turns per-cycle odd/busy stimulus
// into the expected per-cycle trace of stage and counters.
module tb_decoder_stage_controller;
  import decoder_stage_controller_pkg::*;

  localparam int PU = 4;
  localparam int MD = 3;
  localparam int MI = 5;
  localparam int N  = 512;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_round_start = 1'b0;
  logic [3:0]  is_odd_cluster = '0;
  logic [3:0]  is_busy = '0;
  logic [2:0]  global_stage;
  logic [7:0]  iteration_counter;
  logic [31:0] cycle_counter;
  logic        result_valid;
  logic        timeout;

  int checks = 0;
  int errors = 0;

  logic [3:0]  odd_seq [N];
  logic [3:0]  busy_seq[N];
  logic        start_seq[N];
  logic [44:0] exp_tr[N];
  logic [44:0] obs_tr[N];
  int          n_tr;

  decoder_stage_controller #(
    .PU_COUNT(PU), .ITERATION_COUNTER_WIDTH(8),
    .MAXIMUM_DELAY(MD), .MAX_ITERATIONS(MI)
  ) dut (
    .clk(clk), .reset(reset), .new_round_start(new_round_start),
    .is_odd_cluster(is_odd_cluster), .is_busy(is_busy),
    .global_stage(global_stage), .iteration_counter(iteration_counter),
    .cycle_counter(cycle_counter), .result_valid(result_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [44:0] mk(logic [2:0] st, logic [7:0] it, logic [31:0] cy,
                                     logic rv, logic to);
    return {st, it, cy, rv, to};
  endfunction

  function automatic logic [44:0] observe();
    return {global_stage, iteration_counter, cycle_counter, result_valid, timeout};
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      odd_seq[i] = '0; busy_seq[i] = '0; start_seq[i] = 1'b0;
    end
  endtask

  task automatic push(logic [2:0] st, int it, int cy, logic rv, logic to);
    if (n_tr < N) exp_tr[n_tr] = mk(st, 8'(it), 32'(cy), rv, to);
    n_tr++;
  endtask

  // Round model: cycle index 0 is the loading cycle. A MERGE/PEELING stage
  // lasts at least MD cycles and ends on the first busy-free cycle after
  // that; odd flags on that last MERGE cycle decide grow vs peel.
  task automatic build_model();
    int iter, cyc, k, ex;
    logic to;
    logic [2:0] phase;
    bit finished;
    n_tr = 0; iter = 0; cyc = 0; to = 1'b0; finished = 0;
    push(STAGE_MEASUREMENT_LOADING, 0, 0, 1'b0, 1'b0);
    cyc = 1;
    phase = STAGE_MERGE;
    while (!finished && n_tr < N - 8) begin
      k = 0;
      do begin
        push(phase, iter, cyc, 1'b0, to);
        k++; cyc++;
      end while (!(k >= MD && busy_seq[n_tr-1] == 4'b0) && n_tr < N - 8);
      ex = n_tr - 1;
      if (phase == STAGE_MERGE) begin
        if (odd_seq[ex] != 4'b0 && iter < MI) begin
          iter++;
          push(STAGE_GROW, iter, cyc, 1'b0, to);
          cyc++;
        end else begin
          if (odd_seq[ex] != 4'b0) to = 1'b1;
          phase = STAGE_PEELING;
        end
      end else begin
        push(STAGE_RESULT_VALID, iter, cyc, 1'b1, to);
        for (int j = 0; j < 3; j++) push(STAGE_IDLE, iter, cyc, 1'b0, to);
        finished = 1;
      end
    end
  endtask

  // Starts a round from IDLE and records the DUT for n_tr cycles.
  task automatic run_round();
    new_round_start = 1'b1; is_odd_cluster = '0; is_busy = '0;
    @(negedge clk);
    for (int c = 0; c < n_tr && c < N; c++) begin
      obs_tr[c] = observe();
      new_round_start = start_seq[c];
      is_odd_cluster  = odd_seq[c];
      is_busy         = busy_seq[c];
      @(negedge clk);
    end
    new_round_start = 1'b0; is_odd_cluster = '0; is_busy = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1; new_round_start = 1'b1; is_odd_cluster = 4'hF; is_busy = 4'hF;
    repeat (3) @(negedge clk);
    checks++;
    if (observe() !== mk(STAGE_IDLE, 8'd0, 32'd0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL reset_state got %h want %h", observe(),
                         mk(STAGE_IDLE, 8'd0, 32'd0, 1'b0, 1'b0));
    end
    reset = 1'b0; new_round_start = 1'b0; is_odd_cluster = '0; is_busy = '0;
    @(negedge clk);
    checks++;
    if (global_stage !== STAGE_IDLE) begin
      errors++; $display("FAIL reset_idle_hold got %0d want %0d", global_stage, STAGE_IDLE);
    end
  endtask

  task automatic test_zero_syndrome();
    clear_stim(); build_model(); run_round();
    for (int c = 0; c < n_tr; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL zero_trace cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    checks++;
    if (obs_tr[7] !== mk(STAGE_RESULT_VALID, 8'd0, 32'd7, 1'b1, 1'b0)) begin
      errors++; $display("FAIL zero_result got %h want %h", obs_tr[7],
                         mk(STAGE_RESULT_VALID, 8'd0, 32'd7, 1'b1, 1'b0));
    end
  endtask

  task automatic test_one_growth();
    clear_stim();
    for (int c = 1; c <= 3; c++) odd_seq[c] = 4'b0010;
    build_model(); run_round();
    for (int c = 0; c < n_tr; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL growth_trace cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    checks++;
    if (obs_tr[4][44:42] !== STAGE_GROW) begin
      errors++; $display("FAIL growth_stage got %0d want %0d", obs_tr[4][44:42], STAGE_GROW);
    end
    checks++;
    if (obs_tr[11] !== mk(STAGE_RESULT_VALID, 8'd1, 32'd11, 1'b1, 1'b0)) begin
      errors++; $display("FAIL growth_result got %h want %h", obs_tr[11],
                         mk(STAGE_RESULT_VALID, 8'd1, 32'd11, 1'b1, 1'b0));
    end
  endtask

  task automatic test_busy_stall();
    clear_stim();
    for (int c = 1; c <= 10; c++) busy_seq[c] = 4'b1000;
    build_model(); run_round();
    for (int c = 0; c < n_tr; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL busy_trace cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    checks++;
    if (obs_tr[11][44:42] !== STAGE_MERGE || obs_tr[12][44:42] !== STAGE_PEELING) begin
      errors++; $display("FAIL busy_exit got %0d,%0d want %0d,%0d", obs_tr[11][44:42],
                         obs_tr[12][44:42], STAGE_MERGE, STAGE_PEELING);
    end
  endtask

  task automatic test_stuck_odd();
    clear_stim();
    for (int c = 0; c < N; c++) odd_seq[c] = 4'b0001;
    build_model(); run_round();
    for (int c = 0; c < n_tr; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL stuck_trace cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    checks++;
    if (obs_tr[27] !== mk(STAGE_RESULT_VALID, 8'd5, 32'd27, 1'b1, 1'b1)) begin
      errors++; $display("FAIL stuck_result got %h want %h", obs_tr[27],
                         mk(STAGE_RESULT_VALID, 8'd5, 32'd27, 1'b1, 1'b1));
    end
  endtask

  task automatic test_reset_mid_grow();
    bit found;
    int rv_seen;
    found = 0;
    new_round_start = 1'b1; is_odd_cluster = 4'b0001; is_busy = '0;
    @(negedge clk);
    new_round_start = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (global_stage == STAGE_GROW && iteration_counter == 8'd2) found = 1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL midgrow_reach got stage %0d iter %0d want stage %0d iter 2",
                         global_stage, iteration_counter, STAGE_GROW);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (observe() !== mk(STAGE_IDLE, 8'd0, 32'd0, 1'b0, 1'b0)) begin
      errors++; $display("FAIL midgrow_reset got %h want %h", observe(),
                         mk(STAGE_IDLE, 8'd0, 32'd0, 1'b0, 1'b0));
    end
    reset = 1'b0; is_odd_cluster = '0;
    rv_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (result_valid || global_stage != STAGE_IDLE) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin
      errors++; $display("FAIL midgrow_quiet got %0d non-idle cycles want 0", rv_seen);
    end
    clear_stim(); build_model(); run_round();
    for (int c = 0; c < n_tr; c++) begin
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL midgrow_rerun cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
  endtask

  task automatic test_ignored_start();
    int pulses;
    clear_stim();
    start_seq[2] = 1'b1;   // during MERGE
    start_seq[7] = 1'b1;   // during RESULT_VALID
    build_model(); run_round();
    pulses = 0;
    for (int c = 0; c < n_tr; c++) begin
      if (obs_tr[c][1]) pulses++;
      checks++;
      if (obs_tr[c] !== exp_tr[c]) begin
        errors++; $display("FAIL ignore_trace cycle %0d got %h want %h", c, obs_tr[c], exp_tr[c]);
      end
    end
    checks++;
    if (pulses != 1 || obs_tr[8][44:42] !== STAGE_IDLE || obs_tr[10][44:42] !== STAGE_IDLE) begin
      errors++; $display("FAIL ignore_rounds got %0d pulses stage8 %0d stage10 %0d want 1,%0d,%0d",
                         pulses, obs_tr[8][44:42], obs_tr[10][44:42], STAGE_IDLE, STAGE_IDLE);
    end
  endtask

  task automatic test_random();
    int odd_bias, busy_bias, bad;
    for (int r = 0; r < 25; r++) begin
      clear_stim();
      odd_bias  = $urandom_range(1, 8);
      busy_bias = $urandom_range(2, 6);
      for (int c = 0; c < N; c++) begin
        if ($urandom_range(0, 9) < odd_bias) odd_seq[c] = 4'($urandom_range(1, 15));
        if ($urandom_range(0, busy_bias) == 0) busy_seq[c] = 4'($urandom_range(1, 15));
      end
      build_model(); run_round();
      bad = 0;
      for (int c = 0; c < n_tr; c++) begin
        checks++;
        if (obs_tr[c] !== exp_tr[c]) begin
          errors++;
          if (bad < 4) $display("FAIL random_trace round %0d cycle %0d got %h want %h",
                                r, c, obs_tr[c], exp_tr[c]);
          bad++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_zero_syndrome();
    test_one_growth();
    test_busy_stall();
    test_stuck_odd();
    test_reset_mid_grow();
    test_ignored_start();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
